// File: rtl/form_field_checker.sv
// Fixed-form field checker: verifies FIELD_LEN recessive bits after a field-start flag,
// reporting form errors, a last-bit overload request and field completion.
module form_field_checker #(
  parameter int FIELD_LEN     = 7,
  parameter int CNT_W         = 4,
  parameter int OVERLOAD_LAST = 1,
  parameter int ERRCNT_W      = 8
) (
  input  logic                SP,
  input  logic                reset,
  input  logic                RX,
  input  logic                Field_Flag,
  output logic                Form_Error,
  output logic                Overload_Req,
  output logic                Field_Done,
  output logic                Busy,
  output logic [CNT_W-1:0]    Bit_Index,
  output logic [ERRCNT_W-1:0] Err_Count
);

  typedef enum logic {S_IDLE = 1'b0, S_CHECK = 1'b1} state_t;

  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(FIELD_LEN - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_form_error;
  logic                 r_overload_req;
  logic                 r_field_done;
  logic [CNT_W-1:0]     r_bit_index;
  logic [ERRCNT_W-1:0]  r_err_count;

  logic                 w_sample;
  logic                 w_last;
  logic                 w_ovl;
  logic                 w_err;
  logic                 w_done;
  logic [CNT_W-1:0]     w_bit_index_nxt;
  logic [ERRCNT_W-1:0]  w_err_count_nxt;

  // A bit is evaluated on every edge in CHECK, and in IDLE only on the start edge.
  assign w_sample = (r_state == S_CHECK) || !Field_Flag;
  assign w_last   = (r_state == S_IDLE) ? (FIELD_LEN == 1) : (r_bit_index == LAST_IDX);
  assign w_ovl    = w_sample && !RX && w_last && (OVERLOAD_LAST != 0);
  assign w_err    = w_sample && !RX && !w_ovl;
  assign w_done   = (w_sample && RX && w_last) || w_ovl;

  always_ff @(posedge SP or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_sample && RX && !w_last) w_state_nxt = S_CHECK;
      S_CHECK: if (!RX || w_last)             w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bit_index_nxt = '0;
    if (w_state_nxt == S_CHECK)
      w_bit_index_nxt = (r_state == S_IDLE) ? CNT_W'(1) : r_bit_index + CNT_W'(1);
    w_err_count_nxt = r_err_count;
    if (w_err && (r_err_count != ERR_MAX))
      w_err_count_nxt = r_err_count + ERRCNT_W'(1);
  end

  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      r_form_error   <= 1'b1;
      r_overload_req <= 1'b0;
      r_field_done   <= 1'b0;
      r_bit_index    <= '0;
      r_err_count    <= '0;
    end else begin
      r_form_error   <= !w_err;
      r_overload_req <= w_ovl;
      r_field_done   <= w_done;
      r_bit_index    <= w_bit_index_nxt;
      r_err_count    <= w_err_count_nxt;
    end
  end

  assign Form_Error   = r_form_error;
  assign Overload_Req = r_overload_req;
  assign Field_Done   = r_field_done;
  assign Busy         = (r_state == S_CHECK);
  assign Bit_Index    = r_bit_index;
  assign Err_Count    = r_err_count;

endmodule

// File: tb/tb_form_field_checker.sv
// Bench for form_field_checker: four parameter variants driven from one clock,
// with per-edge expected outputs queued at drive time and checked after the edge.
module tb_form_field_checker;

  logic       sp = 1'b0;
  logic       rst;
  logic [3:0] ff_v;
  logic [3:0] rx_v;
  logic [3:0] fe_v, ov_v, dn_v, bz_v;
  logic [3:0] idx0, idx1, idx2, idx3;
  logic [7:0] ec0, ec1, ec2;
  logic [1:0] ec3;

  int          sel;
  logic [15:0] obs;
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cnt[4];

  always #5 sp = ~sp;

  // 0: defaults, 1: OVERLOAD_LAST=0, 2: FIELD_LEN=1 OVERLOAD_LAST=0, 3: ERRCNT_W=2
  form_field_checker u_dflt (
    .SP(sp), .reset(rst), .RX(rx_v[0]), .Field_Flag(ff_v[0]),
    .Form_Error(fe_v[0]), .Overload_Req(ov_v[0]), .Field_Done(dn_v[0]),
    .Busy(bz_v[0]), .Bit_Index(idx0), .Err_Count(ec0));

  form_field_checker #(.OVERLOAD_LAST(0)) u_nol (
    .SP(sp), .reset(rst), .RX(rx_v[1]), .Field_Flag(ff_v[1]),
    .Form_Error(fe_v[1]), .Overload_Req(ov_v[1]), .Field_Done(dn_v[1]),
    .Busy(bz_v[1]), .Bit_Index(idx1), .Err_Count(ec1));

  form_field_checker #(.FIELD_LEN(1), .OVERLOAD_LAST(0)) u_len1 (
    .SP(sp), .reset(rst), .RX(rx_v[2]), .Field_Flag(ff_v[2]),
    .Form_Error(fe_v[2]), .Overload_Req(ov_v[2]), .Field_Done(dn_v[2]),
    .Busy(bz_v[2]), .Bit_Index(idx2), .Err_Count(ec2));

  form_field_checker #(.ERRCNT_W(2)) u_err2 (
    .SP(sp), .reset(rst), .RX(rx_v[3]), .Field_Flag(ff_v[3]),
    .Form_Error(fe_v[3]), .Overload_Req(ov_v[3]), .Field_Done(dn_v[3]),
    .Busy(bz_v[3]), .Bit_Index(idx3), .Err_Count(ec3));

  always_comb begin
    case (sel)
      0:       obs = {fe_v[0], ov_v[0], dn_v[0], bz_v[0], idx0, ec0};
      1:       obs = {fe_v[1], ov_v[1], dn_v[1], bz_v[1], idx1, ec1};
      2:       obs = {fe_v[2], ov_v[2], dn_v[2], bz_v[2], idx2, ec2};
      default: obs = {fe_v[3], ov_v[3], dn_v[3], bz_v[3], idx3, 6'b0, ec3};
    endcase
  end

  function automatic logic [15:0] ev(bit fe, bit ov, bit dn, bit bz, int idx, int c);
    return {fe, ov, dn, bz, 4'(idx), 8'(c)};
  endfunction

  task automatic check_val(string tag, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got fe/ov/dn/bz/idx/cnt=%h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bit to one instance (others idle), queue the expectation, check after the edge.
  task automatic step(int inst, bit f, bit r, logic [15:0] e, string tag);
    logic [15:0] want;
    @(negedge sp);
    ff_v = '1;
    rx_v = '1;
    ff_v[inst] = f;
    rx_v[inst] = r;
    sel = inst;
    exp_q.push_back(e);
    @(posedge sp);
    #1;
    want = exp_q.pop_front();
    check_val(tag, obs, want);
  endtask

  // Seven-bit field; err_pos 0..6 makes that bit dominant, 7 means all recessive.
  task automatic run_field(int inst, int err_pos, bit ol, string tag);
    for (int k = 0; k < 7; k++) begin
      if (k == err_pos) begin
        if (k == 6 && ol) begin
          step(inst, k != 0, 1'b0, ev(1, 1, 1, 0, 0, cnt[inst]), {tag, "_ovl"});
        end else begin
          cnt[inst]++;
          step(inst, k != 0, 1'b0, ev(0, 0, 0, 0, 0, cnt[inst]), {tag, "_err"});
        end
        return;
      end
      if (k == 6) step(inst, 1'b1, 1'b1, ev(1, 0, 1, 0, 0, cnt[inst]), {tag, "_done"});
      else        step(inst, k != 0, 1'b1, ev(1, 0, 0, 1, k + 1, cnt[inst]), {tag, "_bit"});
    end
  endtask

  initial begin
    rst  = 1'b1;
    ff_v = '1;
    rx_v = '1;
    sel  = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (2) @(posedge sp);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      check_val("reset_vals", obs, ev(1, 0, 0, 0, 0, 0));
    end
    @(negedge sp);
    rst = 1'b0;

    run_field(0, 7, 1'b1, "clean");
    run_field(0, 3, 1'b1, "err_bit3");
    for (int i = 0; i < 3; i++)
      step(0, 1'b1, 1'b0, ev(1, 0, 0, 0, 0, cnt[0]), "idle_after_err");
    run_field(0, 6, 1'b1, "last_dflt");
    run_field(1, 6, 1'b0, "last_nol");

    // Back-to-back and gapped fields with random outcomes.
    for (int n = 0; n < 8; n++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(0, 1'b1, 1'($urandom_range(0, 1)), ev(1, 0, 0, 0, 0, cnt[0]), "rand_gap");
      run_field(0, $urandom_range(0, 7), 1'b1, "rand");
    end

    step(2, 1'b0, 1'b1, ev(1, 0, 1, 0, 0, cnt[2]), "len1_done");
    step(2, 1'b0, 1'b1, ev(1, 0, 1, 0, 0, cnt[2]), "len1_b2b");
    cnt[2]++;
    step(2, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, cnt[2]), "len1_err");
    step(2, 1'b1, 1'b0, ev(1, 0, 0, 0, 0, cnt[2]), "len1_idle");

    // Asynchronous reset in the middle of a field.
    step(0, 1'b0, 1'b1, ev(1, 0, 0, 1, 1, cnt[0]), "pre_rst0");
    step(0, 1'b1, 1'b1, ev(1, 0, 0, 1, 2, cnt[0]), "pre_rst1");
    step(0, 1'b1, 1'b1, ev(1, 0, 0, 1, 3, cnt[0]), "pre_rst2");
    @(negedge sp);
    ff_v = '1;
    rx_v = '1;
    #2 rst = 1'b1;
    #1;
    sel = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    check_val("rst_async", obs, ev(1, 0, 0, 0, 0, 0));
    @(negedge sp);
    rst = 1'b0;
    run_field(0, 7, 1'b1, "post_rst");

    // Saturating two-bit error counter.
    for (int i = 0; i < 5; i++) begin
      if (cnt[3] < 3) cnt[3]++;
      step(3, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, cnt[3]), "sat_err");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/form_field_checker.md
# form_field_checker

Parametrised fixed-form field checker for the CAN decoder. It replaces the single-purpose EOF error block and runs off the bit-sample strobe `SP`. After a field-start flag, it verifies that FIELD_LEN consecutive sampled bits are recessive (RX=1). It flags a form error on the first dominant bit, except a dominant last EOF bit, which raises an overload request when OVERLOAD_LAST=1. One instance per fixed-form field: EOF (7), CRC delimiter (1), ACK delimiter (1).

## Interface
Parameters:
- FIELD_LEN, default 7: number of recessive bits checked; legal range 1..(2^CNT_W - 1).
- CNT_W, default 4: width of the bit index.
- OVERLOAD_LAST, default 1: 1 = dominant on the last bit raises an overload request, not an error; 0 = it is a form error.
- ERRCNT_W, default 8: width of the saturating error counter.

Ports:
- SP, in, 1: clock, the bit sample point; all state changes on posedge SP.
- reset, in, 1: asynchronous, active-high.
- RX, in, 1: sampled bus bit; 1 = recessive, 0 = dominant.
- Field_Flag, in, 1: active-low. Low at an SP edge means that edge samples bit 0 of the field. Sampled only in IDLE.
- Form_Error, out, 1: active-low, registered, one-cycle low pulse on the edge that samples an offending bit.
- Overload_Req, out, 1: active-high, one-cycle pulse; dominant last bit with OVERLOAD_LAST=1.
- Field_Done, out, 1: active-high, one-cycle pulse when the field ends without error, including the overload case.
- Busy, out, 1: high while in CHECK.
- Bit_Index, out, CNT_W: index of the next bit to be checked; 0 in IDLE.
- Err_Count, out, ERRCNT_W: saturating count of form errors; cleared only by reset.

## Operation
- States: IDLE, CHECK.
- Pulse defaults: Form_Error=1, Overload_Req=0, Field_Done=0 on every edge unless set by the rules below.
- IDLE, Field_Flag=1: stay in IDLE.
- IDLE, Field_Flag=0: evaluate bit 0 on the same edge.
  - RX=0 (error): Form_Error=0, Err_Count+1, stay in IDLE.
  - RX=1, FIELD_LEN=1: Field_Done=1, stay in IDLE.
  - RX=1, FIELD_LEN>1: go to CHECK with Bit_Index=1.
- CHECK, bit Bit_Index=k:
  - RX=1, k<FIELD_LEN-1: Bit_Index=k+1.
  - RX=1, k=FIELD_LEN-1: Field_Done=1, go to IDLE, Bit_Index=0.
  - RX=0, k<FIELD_LEN-1: Form_Error=0, Err_Count+1, go to IDLE.
  - RX=0, k=FIELD_LEN-1, OVERLOAD_LAST=1: Overload_Req=1, Field_Done=1, go to IDLE, no error.
  - RX=0, k=FIELD_LEN-1, OVERLOAD_LAST=0: treated as a form error.
- Field_Flag is ignored in CHECK; a field cannot be restarted mid-check.
- First-error abort: no further bits of that field are checked.
- Err_Count saturates at 2^ERRCNT_W-1 and does not wrap.
- Bit_Index never exceeds FIELD_LEN-1.
- The FIELD_LEN=1 case never enters CHECK. A dominant bit 0 with FIELD_LEN=1 and OVERLOAD_LAST=1 is an overload (Overload_Req=1, Field_Done=1), not an error.

## Timing
- Reset values: state=IDLE, Form_Error=1, Overload_Req=0, Field_Done=0, Busy=0, Bit_Index=0, Err_Count=0.
- Reset asserted mid-field: all outputs return to reset values immediately; no pulse is emitted.
- Zero-cycle decision latency: every output is registered on the same SP edge that samples the deciding bit. It is valid until the next SP edge.
- Error-free field: Field_Done appears on the SP edge that samples the last bit, FIELD_LEN edges after and including the start edge.
- Back-to-back fields: Field_Flag=0 on the edge right after Field_Done starts a new field. No dead cycle is required.
- Form_Error and Field_Done are never low/high together. Overload_Req implies Field_Done.

## Test plan
- Defaults; Field_Flag=0 at edge 0, RX=1 on 7 edges -> Field_Done=1 at edge 6 only; Form_Error stays 1; Err_Count=0; Busy high on edges 1..6.
- Defaults; RX=0 at edge 3 of the field -> Form_Error=0 at edge 3; Err_Count=1; IDLE at edge 4; no Field_Done; RX ignored after.
- Defaults; RX=0 only at edge 6 -> Overload_Req=1 and Field_Done=1 at edge 6; Form_Error=1. Same stimulus with OVERLOAD_LAST=0 -> Form_Error=0, no Done.
- FIELD_LEN=1, OVERLOAD_LAST=0; Field_Flag=0 with RX=1 -> Field_Done same edge, Busy never 1. Then Field_Flag=0 with RX=0 -> Form_Error=0.
- Defaults; assert reset asynchronously between edges 2 and 3 of a field -> outputs at reset values before the next edge. A new field after reset is checked from bit 0.
- ERRCNT_W=2; 5 consecutive fields each dominant at bit 0 -> Err_Count sequence 1,2,3,3,3; Form_Error pulses 5 times.
